// File: rtl/sdram_port_arbiter.sv
// Shares the single SDRAM controller port between the VGA framebuffer fetcher and the CPU bus.
// Fixed VGA priority with a CPU anti-starvation slot; read returns routed back by an in-order tag FIFO.
module sdram_port_arbiter #(
   parameter int unsigned ADDR_W       = 22,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned MAX_PENDING  = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] vga_addr,
   input  logic              vga_read,
   output logic              vga_waitrequest,
   output logic [DATA_W-1:0] vga_readdata,
   output logic              vga_readdatavalid,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [DATA_W-1:0] cpu_writedata,
   input  logic [1:0]        cpu_byteenable,
   output logic              cpu_waitrequest,
   output logic [DATA_W-1:0] cpu_readdata,
   output logic              cpu_readdatavalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic [1:0]        mem_byteenable,
   input  logic              mem_waitrequest,
   input  logic [DATA_W-1:0] mem_readdata,
   input  logic              mem_readdatavalid,
   output logic              err_orphan
);

   // MAX_PENDING must be a power of two >= 2 so the tag pointers wrap naturally.
   localparam int unsigned PtrW    = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
   localparam int unsigned CntW    = $clog2(MAX_PENDING + 1);
   localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_d;
   logic                read_d, write_d;
   logic [DATA_W-1:0]   wdata_d;
   logic [1:0]          be_d;

   logic [MAX_PENDING-1:0] tag_q;
   logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]        outstanding_q, outstanding_d;
   logic [StarveW-1:0]     starve_q, starve_d;

   logic can_accept, read_ok, cpu_req, cpu_ok, vga_ok, cpu_force;
   logic grant_vga, grant_cpu;
   logic push, pop, orphan, ret_tag;

   always_comb begin
      can_accept = (state_q == StIdle) || !mem_waitrequest;
      read_ok    = outstanding_q < CntW'(MAX_PENDING);
      cpu_req    = cpu_read | cpu_write;
      cpu_ok     = cpu_write | (cpu_read & read_ok);
      vga_ok     = vga_read & read_ok;
      cpu_force  = cpu_req && (starve_q == StarveW'(STARVE_LIMIT));
      grant_vga  = 1'b0;
      grant_cpu  = 1'b0;
      if (can_accept) begin
         if (cpu_force) begin
            grant_cpu = cpu_ok;
         end else if (vga_read) begin
            grant_vga = vga_ok;
         end else begin
            grant_cpu = cpu_ok;
         end
      end
   end

   // Both waitrequests go high combinationally while reset is held.
   assign vga_waitrequest = !(reset && grant_vga);
   assign cpu_waitrequest = !(reset && grant_cpu);

   // A CPU read+write collision is treated as a write, so it never pushes a tag.
   assign push    = grant_vga | (grant_cpu & !cpu_write);
   assign pop     = mem_readdatavalid && (outstanding_q != '0);
   assign orphan  = mem_readdatavalid && (outstanding_q == '0);
   assign ret_tag = tag_q[rd_ptr_q];

   always_comb begin
      state_d = state_q;
      addr_d  = mem_addr;
      read_d  = mem_read;
      write_d = mem_write;
      wdata_d = mem_writedata;
      be_d    = mem_byteenable;
      if (grant_vga) begin
         state_d = StIssue;
         addr_d  = vga_addr;
         read_d  = 1'b1;
         write_d = 1'b0;
         wdata_d = '0;
         be_d    = 2'b11;
      end else if (grant_cpu) begin
         state_d = StIssue;
         addr_d  = cpu_addr;
         read_d  = !cpu_write;
         write_d = cpu_write;
         wdata_d = cpu_writedata;
         be_d    = cpu_byteenable;
      end else if (can_accept) begin
         state_d = StIdle;
         read_d  = 1'b0;
         write_d = 1'b0;
      end
   end

   always_comb begin
      outstanding_d = outstanding_q;
      if (push && !pop) begin
         outstanding_d = outstanding_q + CntW'(1);
      end else if (pop && !push) begin
         outstanding_d = outstanding_q - CntW'(1);
      end
      starve_d = starve_q;
      if (!cpu_req || grant_cpu) begin
         starve_d = '0;
      end else if (grant_vga && (starve_q != StarveW'(STARVE_LIMIT))) begin
         starve_d = starve_q + StarveW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= StIdle;
         mem_addr       <= '0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
         mem_byteenable <= '0;
      end else begin
         state_q        <= state_d;
         mem_addr       <= addr_d;
         mem_read       <= read_d;
         mem_write      <= write_d;
         mem_writedata  <= wdata_d;
         mem_byteenable <= be_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_q         <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         outstanding_q <= '0;
         starve_q      <= '0;
      end else begin
         if (push) begin
            tag_q[wr_ptr_q] <= grant_cpu;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         outstanding_q <= outstanding_d;
         starve_q      <= starve_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vga_readdata      <= '0;
         vga_readdatavalid <= 1'b0;
         cpu_readdata      <= '0;
         cpu_readdatavalid <= 1'b0;
         err_orphan        <= 1'b0;
      end else begin
         vga_readdatavalid <= pop & !ret_tag;
         cpu_readdatavalid <= pop & ret_tag;
         if (pop && !ret_tag) begin
            vga_readdata <= mem_readdata;
         end
         if (pop && ret_tag) begin
            cpu_readdata <= mem_readdata;
         end
         err_orphan <= err_orphan | orphan;
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: grant order, starvation slot, stalls, tag routing,
// outstanding limit, orphan returns and mid-operation reset.
module tb_sdram_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [21:0] vga_addr = '0;
   logic        vga_read = 1'b0;
   logic        vga_waitrequest;
   logic [15:0] vga_readdata;
   logic        vga_readdatavalid;
   logic [21:0] cpu_addr = '0;
   logic        cpu_read = 1'b0;
   logic        cpu_write = 1'b0;
   logic [15:0] cpu_writedata = '0;
   logic [1:0]  cpu_byteenable = '0;
   logic        cpu_waitrequest;
   logic [15:0] cpu_readdata;
   logic        cpu_readdatavalid;
   logic [21:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_writedata;
   logic [1:0]  mem_byteenable;
   logic        mem_waitrequest = 1'b0;
   logic [15:0] mem_readdata = '0;
   logic        mem_readdatavalid = 1'b0;
   logic        err_orphan;

   int checks = 0;
   int failures = 0;

   sdram_port_arbiter #(
      .ADDR_W(22), .DATA_W(16), .MAX_PENDING(4), .STARVE_LIMIT(8)
   ) dut (
      .clk(clk), .reset(reset),
      .vga_addr(vga_addr), .vga_read(vga_read), .vga_waitrequest(vga_waitrequest),
      .vga_readdata(vga_readdata), .vga_readdatavalid(vga_readdatavalid),
      .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
      .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
      .cpu_readdatavalid(cpu_readdatavalid),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
      .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
      .mem_readdatavalid(mem_readdatavalid), .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      vga_read = 1'b1;
      cpu_read = 1'b1;
      next_cycle();
      @(negedge clk);
      checks++;
      if ({mem_read, mem_write, vga_readdatavalid, cpu_readdatavalid, err_orphan} !== 5'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b want=00000",
                  {mem_read, mem_write, vga_readdatavalid, cpu_readdatavalid, err_orphan});
      end
      checks++;
      if ({vga_waitrequest, cpu_waitrequest} !== 2'b11) begin
         failures++;
         $display("FAIL reset_waitrequest got=%b want=11", {vga_waitrequest, cpu_waitrequest});
      end
      checks++;
      if (mem_addr !== 22'h0) begin
         failures++;
         $display("FAIL reset_addr got=%h want=000000", mem_addr);
      end
      next_cycle();
      vga_read = 1'b0;
      cpu_read = 1'b0;
      reset = 1'b1;
      next_cycle();
   endtask

   task automatic test_vga_single();
      vga_read = 1'b1;
      vga_addr = 22'h000100;
      @(negedge clk);
      checks++;
      if ({vga_waitrequest, cpu_waitrequest} !== 2'b01) begin
         failures++;
         $display("FAIL vga1_grant got=%b want=01", {vga_waitrequest, cpu_waitrequest});
      end
      next_cycle();
      vga_read = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_read, mem_write, mem_addr, mem_byteenable, mem_writedata} !==
          {1'b1, 1'b0, 22'h000100, 2'b11, 16'h0000}) begin
         failures++;
         $display("FAIL vga1_cmd got=%b/%b/%h/%b/%h want=1/0/000100/11/0000",
                  mem_read, mem_write, mem_addr, mem_byteenable, mem_writedata);
      end
      for (int c = 2; c <= 6; c++) begin
         next_cycle();
         mem_readdatavalid = (c == 4);
         mem_readdata = (c == 4) ? 16'hBEEF : 16'h0000;
         @(negedge clk);
         if (c == 2) begin
            checks++;
            if (mem_read !== 1'b0) begin
               failures++;
               $display("FAIL vga1_idle got=%b want=0", mem_read);
            end
         end
         checks++;
         if ({vga_readdatavalid, cpu_readdatavalid} !== {(c == 5), 1'b0}) begin
            failures++;
            $display("FAIL vga1_strobe c=%0d got=%b want=%b", c,
                     {vga_readdatavalid, cpu_readdatavalid}, {(c == 5), 1'b0});
         end
         if (c == 5) begin
            checks++;
            if (vga_readdata !== 16'hBEEF) begin
               failures++;
               $display("FAIL vga1_data got=%h want=beef", vga_readdata);
            end
         end
      end
      next_cycle();
   endtask

   task automatic test_starvation();
      logic [15:0] rq_data[$];
      int          rq_due[$];
      int          vga_n = 0, cpu_n = 0, vga_rx = 0, cpu_rx = 0;
      logic        exp_cpu;
      for (int cyc = 0; cyc < 46; cyc++) begin
         mem_readdatavalid = 1'b0;
         if (rq_due.size() > 0 && rq_due[0] == cyc) begin
            mem_readdatavalid = 1'b1;
            mem_readdata = rq_data.pop_front();
            void'(rq_due.pop_front());
         end
         vga_read = (cyc < 40);
         cpu_read = (cyc < 40);
         vga_addr = 22'h001000 + 22'(vga_n);
         cpu_addr = 22'h002000 + 22'(cpu_n);
         @(negedge clk);
         if (cyc < 40) begin
            exp_cpu = (cyc % 9 == 8);
            checks++;
            if ({vga_waitrequest, cpu_waitrequest} !== {exp_cpu, !exp_cpu}) begin
               failures++;
               $display("FAIL starve_grant cyc=%0d got=%b want=%b", cyc,
                        {vga_waitrequest, cpu_waitrequest}, {exp_cpu, !exp_cpu});
            end
            if (exp_cpu) cpu_n++;
            else vga_n++;
         end
         if (mem_read === 1'b1) begin
            rq_data.push_back(mem_addr[15:0]);
            rq_due.push_back(cyc + 2);
         end
         if (vga_readdatavalid === 1'b1) begin
            checks++;
            if (vga_readdata !== 16'h1000 + 16'(vga_rx)) begin
               failures++;
               $display("FAIL starve_vga_data n=%0d got=%h want=%h", vga_rx, vga_readdata,
                        16'h1000 + 16'(vga_rx));
            end
            vga_rx++;
         end
         if (cpu_readdatavalid === 1'b1) begin
            checks++;
            if (cpu_readdata !== 16'h2000 + 16'(cpu_rx)) begin
               failures++;
               $display("FAIL starve_cpu_data n=%0d got=%h want=%h", cpu_rx, cpu_readdata,
                        16'h2000 + 16'(cpu_rx));
            end
            cpu_rx++;
         end
         next_cycle();
      end
      mem_readdatavalid = 1'b0;
      checks++;
      if (vga_rx != 36 || cpu_rx != 4) begin
         failures++;
         $display("FAIL starve_counts got vga=%0d cpu=%0d want vga=36 cpu=4", vga_rx, cpu_rx);
      end
   endtask

   task automatic test_write_stall();
      cpu_write = 1'b1;
      cpu_addr = 22'h3FFFFF;
      cpu_writedata = 16'h1234;
      cpu_byteenable = 2'b01;
      mem_waitrequest = 1'b1;
      @(negedge clk);
      checks++;
      if (cpu_waitrequest !== 1'b0) begin
         failures++;
         $display("FAIL wr_accept got=%b want=0", cpu_waitrequest);
      end
      for (int c = 1; c <= 5; c++) begin
         next_cycle();
         cpu_addr = 22'h000010;
         cpu_writedata = 16'h5555;
         cpu_byteenable = 2'b11;
         @(negedge clk);
         checks++;
         if ({mem_write, mem_read, mem_addr, mem_writedata, mem_byteenable, cpu_waitrequest} !==
             {1'b1, 1'b0, 22'h3FFFFF, 16'h1234, 2'b01, 1'b1}) begin
            failures++;
            $display("FAIL wr_stall c=%0d got=%b/%b/%h/%h/%b wr=%b want=1/0/3fffff/1234/01 wr=1",
                     c, mem_write, mem_read, mem_addr, mem_writedata, mem_byteenable,
                     cpu_waitrequest);
         end
      end
      next_cycle();
      mem_waitrequest = 1'b0;
      @(negedge clk);
      checks++;
      if ({cpu_waitrequest, mem_addr} !== {1'b0, 22'h3FFFFF}) begin
         failures++;
         $display("FAIL wr_release got=%b/%h want=0/3fffff", cpu_waitrequest, mem_addr);
      end
      next_cycle();
      cpu_write = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_write, mem_addr, mem_writedata} !== {1'b1, 22'h000010, 16'h5555}) begin
         failures++;
         $display("FAIL wr_second got=%b/%h/%h want=1/000010/5555",
                  mem_write, mem_addr, mem_writedata);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (mem_write !== 1'b0) begin
         failures++;
         $display("FAIL wr_idle got=%b want=0", mem_write);
      end
      next_cycle();
   endtask

   task automatic test_pending_limit();
      logic [11:0] wr_exp = 12'b1001_0111_0000;
      logic [17:0] ret = 18'b00_1111_0011_0100_0000;
      int          vga_rx = 0;
      int          last_ret = -1;
      vga_addr = 22'h000300;
      for (int c = 0; c < 18; c++) begin
         vga_read = (c < 12);
         mem_readdatavalid = ret[c];
         mem_readdata = 16'hA000 + 16'(c);
         @(negedge clk);
         if (c < 12) begin
            checks++;
            if (vga_waitrequest !== wr_exp[c]) begin
               failures++;
               $display("FAIL limit_wr c=%0d got=%b want=%b", c, vga_waitrequest, wr_exp[c]);
            end
         end
         if (vga_readdatavalid === 1'b1) begin
            checks++;
            if (vga_readdata !== 16'hA000 + 16'(last_ret)) begin
               failures++;
               $display("FAIL limit_data c=%0d got=%h want=%h", c, vga_readdata,
                        16'hA000 + 16'(last_ret));
            end
            vga_rx++;
         end
         checks++;
         if (cpu_readdatavalid !== 1'b0) begin
            failures++;
            $display("FAIL limit_cpu_strobe c=%0d got=%b want=0", c, cpu_readdatavalid);
         end
         last_ret = ret[c] ? c : -1;
         next_cycle();
      end
      mem_readdatavalid = 1'b0;
      checks++;
      if (vga_rx != 7) begin
         failures++;
         $display("FAIL limit_count got=%0d want=7", vga_rx);
      end
   endtask

   task automatic test_orphan();
      mem_readdatavalid = 1'b1;
      mem_readdata = 16'hDEAD;
      @(negedge clk);
      checks++;
      if (err_orphan !== 1'b0) begin
         failures++;
         $display("FAIL orphan_pre got=%b want=0", err_orphan);
      end
      for (int c = 1; c <= 3; c++) begin
         next_cycle();
         mem_readdatavalid = 1'b0;
         @(negedge clk);
         checks++;
         if ({err_orphan, vga_readdatavalid, cpu_readdatavalid} !== 3'b100) begin
            failures++;
            $display("FAIL orphan_set c=%0d got=%b want=100", c,
                     {err_orphan, vga_readdatavalid, cpu_readdatavalid});
         end
      end
      next_cycle();
   endtask

   task automatic test_reset_midop();
      vga_read = 1'b1;
      vga_addr = 22'h000200;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (vga_waitrequest !== 1'b0) begin
            failures++;
            $display("FAIL rst_issue c=%0d got=%b want=0", c, vga_waitrequest);
         end
         next_cycle();
      end
      cpu_read = 1'b1;
      checks++;
      if (mem_read !== 1'b1) begin
         failures++;
         $display("FAIL rst_before got=%b want=1", mem_read);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({mem_read, vga_waitrequest, cpu_waitrequest, mem_addr} !== {3'b011, 22'h0}) begin
         failures++;
         $display("FAIL rst_immediate got=%b/%b/%b/%h want=0/1/1/000000",
                  mem_read, vga_waitrequest, cpu_waitrequest, mem_addr);
      end
      next_cycle();
      next_cycle();
      vga_read = 1'b0;
      cpu_read = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (err_orphan !== 1'b0) begin
         failures++;
         $display("FAIL rst_orphan_clear got=%b want=0", err_orphan);
      end
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         mem_readdatavalid = (c < 3);
         mem_readdata = 16'hC000 + 16'(c);
         @(negedge clk);
         checks++;
         if ({vga_readdatavalid, cpu_readdatavalid} !== 2'b00) begin
            failures++;
            $display("FAIL rst_late_strobe c=%0d got=%b want=00", c,
                     {vga_readdatavalid, cpu_readdatavalid});
         end
      end
      mem_readdatavalid = 1'b0;
      checks++;
      if (err_orphan !== 1'b1) begin
         failures++;
         $display("FAIL rst_late_orphan got=%b want=1", err_orphan);
      end
   endtask

   initial begin
      test_reset();
      test_vga_single();
      test_starvation();
      test_write_stall();
      test_pending_limit();
      test_orphan();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
